// File: rtl/rover_motion_sequencer.sv
// Rover motion sequencer: listens for sound, hands control to localization when heard,
// otherwise sweeps rotate/forward search legs and halts after MAX_SEARCH fruitless legs.
module rover_motion_sequencer #(
    parameter int unsigned LISTEN_CYCLES     = 25000000,
    parameter int unsigned SEARCH_ROT_CYCLES = 50000000,
    parameter int unsigned SEARCH_FWD_CYCLES = 100000000,
    parameter int unsigned SETTLE_CYCLES     = 10000000,
    parameter int unsigned MAX_SEARCH        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       mic_activity,
    input  logic       loc_dir,
    input  logic       loc_rot,
    input  logic       loc_move,
    output logic       direction,
    output logic       rotate,
    output logic       move,
    output logic [2:0] state,
    output logic [3:0] search_cycle,
    output logic       halted
);
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LISTEN     = 3'd1,
        S_TRACK      = 3'd2,
        S_SETTLE     = 3'd3,
        S_SEARCH_ROT = 3'd4,
        S_SEARCH_FWD = 3'd5,
        S_HALT       = 3'd6
    } state_t;

    localparam logic [26:0] LISTEN_LAST = 27'(LISTEN_CYCLES - 1);
    localparam logic [26:0] ROT_LAST    = 27'(SEARCH_ROT_CYCLES - 1);
    localparam logic [26:0] FWD_LAST    = 27'(SEARCH_FWD_CYCLES - 1);
    localparam logic [26:0] SETTLE_LAST = 27'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  MAX_SC      = 4'(MAX_SEARCH);

    state_t      r_state     = S_IDLE;
    logic [26:0] r_timer     = '0;
    logic [3:0]  r_search    = '0;
    logic        r_dir       = 1'b0;
    logic        r_rot       = 1'b0;
    logic        r_move      = 1'b0;
    logic        r_halted    = 1'b0;
    logic        r_prev_move = 1'b0;
    logic        r_seen_move = 1'b0;

    state_t      w_next;
    logic [3:0]  w_search_next;
    logic [3:0]  w_search_inc;

    assign w_search_inc = (r_search == 4'd15) ? 4'd15 : r_search + 4'd1;

    always_comb begin
        w_next        = r_state;
        w_search_next = r_search;
        if (!enable) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_next = S_LISTEN;
                S_LISTEN: begin
                    if (mic_activity)              w_next = S_TRACK;
                    else if (r_timer == LISTEN_LAST) w_next = S_SEARCH_ROT;
                end
                // Falling edge needs two in-TRACK samples; the quiet exit requires no high sample at all.
                S_TRACK: begin
                    if (r_prev_move && !loc_move)
                        w_next = S_SETTLE;
                    else if (!r_seen_move && !loc_move && r_timer == LISTEN_LAST)
                        w_next = S_LISTEN;
                end
                S_SETTLE: if (r_timer == SETTLE_LAST) w_next = S_LISTEN;
                S_SEARCH_ROT: begin
                    if (mic_activity)           w_next = S_TRACK;
                    else if (r_timer == ROT_LAST) w_next = S_SEARCH_FWD;
                end
                S_SEARCH_FWD: begin
                    if (mic_activity) begin
                        w_next = S_TRACK;
                    end else if (r_timer == FWD_LAST) begin
                        w_search_next = w_search_inc;
                        w_next        = (w_search_inc == MAX_SC) ? S_HALT : S_LISTEN;
                    end
                end
                S_HALT:  w_next = S_HALT;
                default: w_next = S_IDLE;
            endcase
            if (w_next == S_TRACK && r_state != S_TRACK)
                w_search_next = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_search    <= '0;
            r_dir       <= 1'b0;
            r_rot       <= 1'b0;
            r_move      <= 1'b0;
            r_halted    <= 1'b0;
            r_prev_move <= 1'b0;
            r_seen_move <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_search <= w_search_next;
            r_timer  <= (w_next != r_state) ? 27'd0 : r_timer + 27'd1;
            r_halted <= (w_next == S_HALT);
            // Outputs come from the state being entered, so they never lag the state code.
            case (w_next)
                S_TRACK:      {r_dir, r_rot, r_move} <= {loc_dir, loc_rot, loc_move};
                S_SEARCH_ROT: {r_dir, r_rot, r_move} <= 3'b111;
                S_SEARCH_FWD: {r_dir, r_rot, r_move} <= 3'b101;
                default:      {r_dir, r_rot, r_move} <= 3'b000;
            endcase
            if (r_state == S_TRACK) begin
                r_prev_move <= loc_move;
                r_seen_move <= r_seen_move | loc_move;
            end else begin
                r_prev_move <= 1'b0;
                r_seen_move <= 1'b0;
            end
        end
    end

    assign state        = r_state;
    assign search_cycle = r_search;
    assign direction    = r_dir;
    assign rotate       = r_rot;
    assign move         = r_move;
    assign halted       = r_halted;
endmodule

// File: tb/tb_rover_motion_sequencer.sv
// Bench for rover_motion_sequencer: stimulus table plus hand sequences, every cycle checked
// against hand-derived expectations via an expected-result queue.
module tb_rover_motion_sequencer;
    localparam int ST_IDLE = 0, ST_LISTEN = 1, ST_TRACK = 2, ST_SETTLE = 3;
    localparam int ST_ROT = 4, ST_FWD = 5, ST_HALT = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1, enable = 1'b0, mic_activity = 1'b0;
    logic       loc_dir = 1'b0, loc_rot = 1'b0, loc_move = 1'b0;
    logic       direction, rotate, move, halted;
    logic [2:0] state;
    logic [3:0] search_cycle;

    always #5 clk = ~clk;

    rover_motion_sequencer #(
        .LISTEN_CYCLES(8), .SEARCH_ROT_CYCLES(4), .SEARCH_FWD_CYCLES(6),
        .SETTLE_CYCLES(3), .MAX_SEARCH(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mic_activity(mic_activity),
        .loc_dir(loc_dir), .loc_rot(loc_rot), .loc_move(loc_move),
        .direction(direction), .rotate(rotate), .move(move),
        .state(state), .search_cycle(search_cycle), .halted(halted)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       d, r, m;
        logic [3:0] sc;
        logic       h;
    } exp_t;

    typedef struct {
        int   rep;
        logic rst, en, mic, ld, lr, lm;
        exp_t e;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   n_chk = 0, n_pass = 0, n_step = 0;

    function automatic exp_t mk(input int st, input logic d, r, m, input int sc, input logic h);
        exp_t e;
        e.st = 3'(st); e.d = d; e.r = r; e.m = m; e.sc = 4'(sc); e.h = h;
        return e;
    endfunction

    task automatic add(input int rep, input logic rst, en, mic, ld, lr, lm, input exp_t e);
        vec_t v;
        v.rep = rep; v.rst = rst; v.en = en; v.mic = mic;
        v.ld = ld; v.lr = lr; v.lm = lm; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic step(input logic rst, en, mic, ld, lr, lm, input exp_t e);
        exp_t got, want;
        reset = rst; enable = en; mic_activity = mic;
        loc_dir = ld; loc_rot = lr; loc_move = lm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        n_step++;
        got  = {state, direction, rotate, move, search_cycle, halted};
        want = exp_q.pop_front();
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL step%0d: got st=%0d drm=%b%b%b sc=%0d h=%b, want st=%0d drm=%b%b%b sc=%0d h=%b",
                      n_step, got.st, got.d, got.r, got.m, got.sc, got.h,
                      want.st, want.d, want.r, want.m, want.sc, want.h);
    endtask

    task automatic steps(input int n, input logic rst, en, mic, ld, lr, lm, input exp_t e);
        for (int i = 0; i < n; i++) step(rst, en, mic, ld, lr, lm, e);
    endtask

    // From a fresh LISTEN entry: full listen window, rotate leg, and into the forward leg.
    task automatic to_fwd(input int sc);
        steps(7, 0, 1, 0, 0, 0, 0, mk(ST_LISTEN, 0, 0, 0, sc, 0));
        steps(4, 0, 1, 0, 0, 0, 0, mk(ST_ROT, 1, 1, 1, sc, 0));
        step(0, 1, 0, 0, 0, 0, mk(ST_FWD, 1, 0, 1, sc, 0));
    endtask

    task automatic quiet_pass(input int sc_in, input int sc_out, input logic to_halt);
        to_fwd(sc_in);
        steps(5, 0, 1, 0, 0, 0, 0, mk(ST_FWD, 1, 0, 1, sc_in, 0));
        if (to_halt) step(0, 1, 0, 0, 0, 0, mk(ST_HALT, 0, 0, 0, sc_out, 1));
        else         step(0, 1, 0, 0, 0, 0, mk(ST_LISTEN, 0, 0, 0, sc_out, 0));
    endtask

    initial begin
        // rep, rst, en, mic, ld, lr, lm, expected
        add(1, 1, 0, 0, 0, 0, 0, mk(ST_IDLE,   0, 0, 0, 0, 0));
        add(1, 0, 0, 0, 0, 0, 0, mk(ST_IDLE,   0, 0, 0, 0, 0));
        add(1, 0, 1, 0, 0, 0, 0, mk(ST_LISTEN, 0, 0, 0, 0, 0));
        add(7, 0, 1, 0, 0, 0, 0, mk(ST_LISTEN, 0, 0, 0, 0, 0));
        add(1, 0, 1, 1, 1, 0, 0, mk(ST_TRACK,  1, 0, 0, 0, 0));
        add(3, 0, 1, 1, 0, 1, 0, mk(ST_TRACK,  0, 1, 0, 0, 0));
        add(4, 0, 1, 0, 0, 0, 0, mk(ST_TRACK,  0, 0, 0, 0, 0));
        add(1, 0, 1, 0, 0, 0, 0, mk(ST_LISTEN, 0, 0, 0, 0, 0));
        add(1, 0, 1, 1, 0, 0, 0, mk(ST_TRACK,  0, 0, 0, 0, 0));
        add(5, 0, 1, 0, 1, 0, 1, mk(ST_TRACK,  1, 0, 1, 0, 0));
        add(1, 0, 1, 0, 1, 0, 0, mk(ST_SETTLE, 0, 0, 0, 0, 0));
        add(2, 0, 1, 1, 0, 0, 0, mk(ST_SETTLE, 0, 0, 0, 0, 0));
        add(1, 0, 1, 0, 0, 0, 0, mk(ST_LISTEN, 0, 0, 0, 0, 0));
        add(1, 0, 0, 1, 0, 0, 0, mk(ST_IDLE,   0, 0, 0, 0, 0));
        add(1, 0, 1, 0, 0, 0, 0, mk(ST_LISTEN, 0, 0, 0, 0, 0));

        foreach (tbl[k])
            steps(tbl[k].rep, tbl[k].rst, tbl[k].en, tbl[k].mic,
                  tbl[k].ld, tbl[k].lr, tbl[k].lm, tbl[k].e);

        // Two quiet passes reach MAX_SEARCH and halt; HALT ignores sound.
        quiet_pass(0, 1, 0);
        quiet_pass(1, 2, 1);
        steps(3, 0, 1, 1, 1, 1, 1, mk(ST_HALT, 0, 0, 0, 2, 1));
        step(0, 0, 0, 0, 0, 0, mk(ST_IDLE, 0, 0, 0, 2, 0));
        step(0, 1, 0, 0, 0, 0, mk(ST_LISTEN, 0, 0, 0, 2, 0));

        // Past MAX_SEARCH the count keeps climbing and saturates at 15.
        for (int k = 3; k <= 16; k++)
            quiet_pass((k - 1 > 15) ? 15 : k - 1, (k > 15) ? 15 : k, 0);

        // Sound on the second rotate cycle pre-empts the leg and clears the count.
        steps(7, 0, 1, 0, 0, 0, 0, mk(ST_LISTEN, 0, 0, 0, 15, 0));
        steps(2, 0, 1, 0, 0, 0, 0, mk(ST_ROT, 1, 1, 1, 15, 0));
        step(0, 1, 1, 0, 1, 1, mk(ST_TRACK, 0, 1, 1, 0, 0));
        step(0, 1, 0, 1, 0, 1, mk(ST_TRACK, 1, 0, 1, 0, 0));
        step(0, 1, 0, 1, 0, 0, mk(ST_SETTLE, 0, 0, 0, 0, 0));
        steps(2, 0, 1, 0, 0, 0, 0, mk(ST_SETTLE, 0, 0, 0, 0, 0));
        step(0, 1, 0, 0, 0, 0, mk(ST_LISTEN, 0, 0, 0, 0, 0));

        // Reset mid forward leg overrides enable and sound.
        quiet_pass(0, 1, 0);
        to_fwd(1);
        steps(2, 0, 1, 0, 0, 0, 0, mk(ST_FWD, 1, 0, 1, 1, 0));
        step(1, 1, 1, 1, 1, 1, mk(ST_IDLE, 0, 0, 0, 0, 0));
        step(0, 1, 0, 0, 0, 0, mk(ST_LISTEN, 0, 0, 0, 0, 0));

        // Sound coincident with forward-leg expiry wins over the count increment.
        to_fwd(0);
        steps(5, 0, 1, 0, 0, 0, 0, mk(ST_FWD, 1, 0, 1, 0, 0));
        step(0, 1, 1, 1, 1, 0, mk(ST_TRACK, 1, 1, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
